// File: rtl/lsu_tcm_responder_pkg.sv
// Shared LSU request/ack types, AMO and size codes, and the DTCM feature block.
// Feature macro: SOPHON_TCM_AMO_EN enables atomics and the LR/SC reservation.
package lsu_tcm_responder_pkg;

  localparam logic [31:0] DTCM_BASE = 32'h1000_0000;
  localparam logic [31:0] DTCM_SIZE = 32'h0000_0400;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  amo;
    logic [1:0]  size;
    logic [3:0]  strb;
  } lsu_req_t;

  typedef struct packed {
    logic        ack;
    logic        error;
    logic [31:0] rdata;
  } lsu_ack_t;

  localparam logic [3:0] AMO_NONE = 4'h0;
  localparam logic [3:0] AMO_SWAP = 4'h1;
  localparam logic [3:0] AMO_ADD  = 4'h2;
  localparam logic [3:0] AMO_XOR  = 4'h3;
  localparam logic [3:0] AMO_AND  = 4'h4;
  localparam logic [3:0] AMO_OR   = 4'h5;
  localparam logic [3:0] AMO_MIN  = 4'h6;
  localparam logic [3:0] AMO_MAX  = 4'h7;
  localparam logic [3:0] AMO_MINU = 4'h8;
  localparam logic [3:0] AMO_MAXU = 4'h9;
  localparam logic [3:0] AMO_LR   = 4'hA;
  localparam logic [3:0] AMO_SC   = 4'hB;

  localparam logic [1:0] LSU_SIZE_B = 2'd0;
  localparam logic [1:0] LSU_SIZE_H = 2'd1;
  localparam logic [1:0] LSU_SIZE_W = 2'd2;

  // Feature block: the responder state set follows the atomics option.
`ifdef SOPHON_TCM_AMO_EN
  localparam bit TCM_AMO_EN = 1'b1;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_AMO_WR = 2'd1, ST_RESP = 2'd2} tcm_state_e;
`else
  localparam bit TCM_AMO_EN = 1'b0;
  typedef enum logic {ST_IDLE = 1'b0, ST_RESP = 1'b1} tcm_state_e;
`endif

endpackage

// File: rtl/lsu_amo_alu.sv
// Combinational AMO datapath: new memory word from the old word and the operand.
// Present only when SOPHON_TCM_AMO_EN is defined.
`ifdef SOPHON_TCM_AMO_EN
module lsu_amo_alu
  import lsu_tcm_responder_pkg::*;
(
  input  logic [3:0]  amo,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] new_word
);

  always_comb begin
    new_word = old_word;
    case (amo)
      AMO_SWAP: new_word = wdata;
      AMO_ADD:  new_word = old_word + wdata;
      AMO_XOR:  new_word = old_word ^ wdata;
      AMO_AND:  new_word = old_word & wdata;
      AMO_OR:   new_word = old_word | wdata;
      AMO_MIN:  new_word = ($signed(old_word) < $signed(wdata)) ? old_word : wdata;
      AMO_MAX:  new_word = ($signed(old_word) > $signed(wdata)) ? old_word : wdata;
      AMO_MINU: new_word = (old_word < wdata) ? old_word : wdata;
      AMO_MAXU: new_word = (old_word > wdata) ? old_word : wdata;
      default:  ;
    endcase
  end

endmodule
`endif

// File: rtl/lsu_tcm_responder.sv
// DTCM responder: word memory servicing LSU loads, strobed stores and optional atomics.
// Feature macro: SOPHON_TCM_AMO_EN adds the AMO_WR state, AMO ALU and LR/SC reservation.
//
// state     | meaning
// ST_IDLE   | waiting for req; checks, reads and stores happen here
// ST_AMO_WR | second half of an AMO 1-9: write f(old, wdata)
// ST_RESP   | ack=1 for one cycle, then back to ST_IDLE
module lsu_tcm_responder
  import lsu_tcm_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DTCM_BASE,
  parameter logic [31:0] SIZE_BYTES = DTCM_SIZE
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  lsu_req_t lsu_req_i,
  output lsu_ack_t lsu_ack_o
);

  localparam int unsigned DEPTH = SIZE_BYTES / 4;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tcm_state_e       state_q, state_d;
  lsu_ack_t         ack_q, ack_d;
  logic [31:0]      mem [DEPTH];
  logic [31:0]      off, rd_word, mem_wd;
  logic [IDX_W-1:0] idx;
  logic [3:0]       mem_be;
  logic             mem_we_raw, mem_we;
  logic             oor, misaligned, amo_bad, req_err;

  assign off        = lsu_req_i.addr - BASE_ADDR;
  assign idx        = off[IDX_W+1:2];
  assign rd_word    = mem[idx];
  assign oor        = off >= SIZE_BYTES;
  assign misaligned = (lsu_req_i.size == 2'd3)
                   || (lsu_req_i.size == LSU_SIZE_H && lsu_req_i.addr[0] != 1'b0)
                   || (lsu_req_i.size == LSU_SIZE_W && lsu_req_i.addr[1:0] != 2'b00);
  assign amo_bad    = (lsu_req_i.amo != AMO_NONE)
                   && (!TCM_AMO_EN || lsu_req_i.size != LSU_SIZE_W || lsu_req_i.amo > AMO_SC);
  assign req_err    = oor || misaligned || amo_bad;

  // A write still pending when reset asserts must never land in memory.
  assign mem_we     = mem_we_raw & rst_ni;
  assign lsu_ack_o  = ack_q;

`ifdef SOPHON_TCM_AMO_EN
  logic [31:0]      old_q, old_d, alu_new;
  logic             rsv_valid_q, rsv_valid_d;
  logic [IDX_W-1:0] rsv_addr_q, rsv_addr_d;

  lsu_amo_alu u_amo_alu (
    .amo      (lsu_req_i.amo),
    .old_word (old_q),
    .wdata    (lsu_req_i.wdata),
    .new_word (alu_new)
  );
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      ack_q       <= '0;
`ifdef SOPHON_TCM_AMO_EN
      old_q       <= '0;
      rsv_valid_q <= 1'b0;
      rsv_addr_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
`ifdef SOPHON_TCM_AMO_EN
      old_q       <= old_d;
      rsv_valid_q <= rsv_valid_d;
      rsv_addr_q  <= rsv_addr_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem[idx][8*i +: 8] <= mem_wd[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ack_d      = '0;
    mem_we_raw = 1'b0;
    mem_be     = 4'h0;
    mem_wd     = '0;
`ifdef SOPHON_TCM_AMO_EN
    old_d       = old_q;
    rsv_valid_d = rsv_valid_q;
    rsv_addr_d  = rsv_addr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (lsu_req_i.req) begin
          state_d   = ST_RESP;
          ack_d.ack = 1'b1;
          if (req_err) begin
            ack_d.error = 1'b1;
          end else if (lsu_req_i.amo == AMO_NONE) begin
            if (lsu_req_i.we) begin
              mem_we_raw = 1'b1;
              mem_be     = lsu_req_i.strb;
              mem_wd     = lsu_req_i.wdata;
            end else begin
              ack_d.rdata = rd_word;
            end
          end
`ifdef SOPHON_TCM_AMO_EN
          else if (lsu_req_i.amo == AMO_LR) begin
            ack_d.rdata = rd_word;
            rsv_valid_d = 1'b1;
            rsv_addr_d  = idx;
          end else if (lsu_req_i.amo == AMO_SC) begin
            if (rsv_valid_q && rsv_addr_q == idx) begin
              mem_we_raw = 1'b1;
              mem_be     = 4'hF;
              mem_wd     = lsu_req_i.wdata;
            end else begin
              ack_d.rdata = 32'd1;
            end
            rsv_valid_d = 1'b0;
          end else begin
            old_d   = rd_word;
            state_d = ST_AMO_WR;
            ack_d   = '0;
          end
`endif
        end
      end
`ifdef SOPHON_TCM_AMO_EN
      ST_AMO_WR: begin
        mem_we_raw  = 1'b1;
        mem_be      = 4'hF;
        mem_wd      = alu_new;
        state_d     = ST_RESP;
        ack_d.ack   = 1'b1;
        ack_d.rdata = old_q;
      end
`endif
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`ifdef SOPHON_TCM_AMO_EN
    // Any write landing on the reserved word breaks the reservation.
    if (mem_we_raw && rsv_addr_q == idx) rsv_valid_d = 1'b0;
`endif
  end

endmodule

// File: tb/tb_lsu_tcm_responder.sv
// Self-checking bench for lsu_tcm_responder: transaction-level memory/reservation
// model plus a per-cycle ack monitor; follows SOPHON_TCM_AMO_EN like the RTL.
module tb_lsu_tcm_responder;
  import lsu_tcm_responder_pkg::*;

  localparam logic [31:0] B     = DTCM_BASE;
  localparam logic [31:0] SZ    = DTCM_SIZE;
  localparam int          DEPTH = int'(SZ / 4);

  logic     clk, rst_n;
  lsu_req_t req;
  lsu_ack_t ack;

  lsu_tcm_responder #(.BASE_ADDR(B), .SIZE_BYTES(SZ)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .lsu_req_i (req),
    .lsu_ack_o (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  logic [31:0] mm [DEPTH];
  bit          rsv_v = 1'b0;
  int          rsv_a = 0;

  int          exp_cyc = -10;
  logic        exp_err;
  logic [31:0] exp_rd;
  logic [31:0] last_rd  = '0;
  logic        last_err = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, expv);
  endtask

  function automatic logic [31:0] amo_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a; sb = b;
    case (op)
      4'h1: return b;
      4'h2: return a + b;
      4'h3: return a ^ b;
      4'h4: return a & b;
      4'h5: return a | b;
      4'h6: return (sa <= sb) ? a : b;
      4'h7: return (sa >= sb) ? a : b;
      4'h8: return (a <= b) ? a : b;
      4'h9: return (a >= b) ? a : b;
      default: return a;
    endcase
  endfunction

  // Applies one transaction to the model; returns expected error, rdata, ack latency.
  task automatic model_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] amo, input logic [1:0] size, input logic [3:0] strb,
                           output logic e, output logic [31:0] rd, output int lat);
    logic [31:0] off;
    int w;
    off = addr - B;
    lat = 1;
    rd  = 32'd0;
    e = (off >= SZ) || (size == 2'd3) || (size == 2'd1 && addr[0]) ||
        (size == 2'd2 && addr[1:0] != 2'd0) ||
        (amo != 4'd0 && (!TCM_AMO_EN || size != 2'd2 || amo > 4'hB));
    w = int'(off >> 2);
    if (e) return;
    if (amo == 4'd0) begin
      if (we) begin
        for (int i = 0; i < 4; i++) if (strb[i]) mm[w][8*i +: 8] = wdata[8*i +: 8];
        if (rsv_a == w) rsv_v = 1'b0;
      end else rd = mm[w];
    end else if (amo == 4'hA) begin
      rd = mm[w]; rsv_v = 1'b1; rsv_a = w;
    end else if (amo == 4'hB) begin
      if (rsv_v && rsv_a == w) mm[w] = wdata;
      else rd = 32'd1;
      rsv_v = 1'b0;
    end else begin
      rd = mm[w];
      mm[w] = amo_f(amo, mm[w], wdata);
      lat = 2;
      if (rsv_a == w) rsv_v = 1'b0;
    end
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] amo, input logic [1:0] size, input logic [3:0] strb);
    logic e; logic [31:0] rd; int lat;
    model_txn(we, addr, wdata, amo, size, strb, e, rd, lat);
    @(posedge clk); #1;
    req.req = 1'b1; req.we = we; req.addr = addr; req.wdata = wdata;
    req.amo = amo; req.size = size; req.strb = strb;
    exp_err = e; exp_rd = rd; exp_cyc = cyc + lat;
    while (cyc < exp_cyc) begin @(posedge clk); #1; end
    @(negedge clk); #1;
    req.req = 1'b0;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF,
                    input logic [1:0] sz = 2'd2);
    txn(1'b1, a, d, 4'h0, sz, s);
  endtask
  task automatic ld(input logic [31:0] a, input logic [1:0] sz = 2'd2);
    txn(1'b0, a, 32'h0, 4'h0, sz, 4'h0);
  endtask
  task automatic at(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
    txn(1'b0, a, d, op, 2'd2, 4'hF);
  endtask

  // Reset asserted while a request is in flight; nothing may be acked or written.
  task automatic rst_mid(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    req.req = 1'b1; req.addr = a; req.wdata = d; req.size = 2'd2; req.strb = 4'hF;
    exp_cyc = -10;
`ifdef SOPHON_TCM_AMO_EN
    req.we = 1'b0; req.amo = 4'h2;
    @(posedge clk); #1;
`else
    req.we = 1'b1; req.amo = 4'h0;
    #2;
`endif
    rst_n = 1'b0;
    #1;
    chk("ack_cleared_by_reset", {ack.ack, ack.error, ack.rdata}, 34'd0);
    req.req = 1'b0;
    rsv_v = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Per-cycle monitor: ack only where the model expects it, zeros otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_ack", {ack.ack, ack.error, ack.rdata}, 34'd0);
    end else if (cyc == exp_cyc) begin
      chk("ack_high", ack.ack, 1'b1);
      chk("ack_error", ack.error, exp_err);
      chk("ack_rdata", ack.rdata, exp_rd);
      last_rd  = ack.rdata;
      last_err = ack.error;
    end else begin
      chk("idle_outputs", {ack.ack, ack.error, ack.rdata}, 34'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("after_reset_ack", {ack.ack, ack.error, ack.rdata}, 34'd0);

    // word store then load
    st(B + 32'h10, 32'hDEADBEEF);
    ld(B + 32'h10);
    chk("lit_store_load", last_rd, 32'hDEADBEEF);

    // byte-strobed store
    st(B + 32'h10, 32'h11223344);
    st(B + 32'h11, 32'h0000AB00, 4'b0010, 2'd0);
    ld(B + 32'h10);
    chk("lit_byte_store", last_rd, 32'h1122AB44);
    st(B + 32'h12, 32'h00CD0000, 4'b0000, 2'd1);
    ld(B + 32'h10);
    chk("lit_strb0_noop", last_rd, 32'h1122AB44);

    // window edges
    st(B, 32'hA0A0A0A0);
    st(B + SZ - 4, 32'h5A5A5A5A);
    ld(B + SZ - 4);
    chk("lit_last_word", last_rd, 32'h5A5A5A5A);

    // error cases, each store aimed at a word an unchecked decoder would hit
    st(B + SZ, 32'hFFFF0000);
    chk("lit_err_above", {last_err, last_rd}, {1'b1, 32'h0});
    st(B - 4, 32'hFFFF0001);
    chk("lit_err_below", {last_err, last_rd}, {1'b1, 32'h0});
    st(B + 32'h12, 32'hFFFF0002);
    chk("lit_err_misal_w", {last_err, last_rd}, {1'b1, 32'h0});
    st(B + 32'h10, 32'hFFFF0003, 4'hF, 2'd3);
    chk("lit_err_size3", {last_err, last_rd}, {1'b1, 32'h0});
    ld(B + 32'h11, 2'd1);
    txn(1'b1, B + 32'h10, 32'hFFFF0004, 4'h3, 2'd0, 4'hF);
    txn(1'b1, B + 32'h10, 32'hFFFF0005, 4'hC, 2'd2, 4'hF);
    ld(B + 32'h10);
    chk("lit_err_nochange", last_rd, 32'h1122AB44);
    ld(B);
    ld(B + SZ - 4);
    ld(B + 32'h12, 2'd1);
    ld(B + 32'h13, 2'd0);

    // atomics (error acks when compiled out)
    st(B + 32'h20, 32'hFFFFFFFF);
    at(4'h2, B + 32'h20, 32'h2);
`ifdef SOPHON_TCM_AMO_EN
    chk("lit_amo_add_old", last_rd, 32'hFFFFFFFF);
`else
    chk("lit_amo_off_err", {last_err, last_rd}, {1'b1, 32'h0});
`endif
    ld(B + 32'h20);
`ifdef SOPHON_TCM_AMO_EN
    chk("lit_amo_add_new", last_rd, 32'h00000001);
`else
    chk("lit_amo_off_keep", last_rd, 32'hFFFFFFFF);
`endif
    st(B + 32'h24, 32'h80000000);
    at(4'h6, B + 32'h24, 32'h1);
    ld(B + 32'h24);
    chk("lit_amo_min", last_rd, 32'h80000000);

    begin
      logic [3:0]  ops  [8] = '{4'h1, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'h9, 4'h6};
      logic [31:0] init [8] = '{32'h0F0F0F0F, 32'hFF00FF00, 32'hF0F0F0F0, 32'h0000FFFF,
                                32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000007, 32'h00000005};
      logic [31:0] opd  [8] = '{32'hA5A5A5A5, 32'h0FF00FF0, 32'h3C3C3C3C, 32'h12340000,
                                32'h00000005, 32'h00000005, 32'h80000000, 32'hFFFFFFFE};
      for (int i = 0; i < 8; i++) begin
        st(B + 32'h40, init[i]);
        at(ops[i], B + 32'h40, opd[i]);
        ld(B + 32'h40);
      end
    end
`ifdef SOPHON_TCM_AMO_EN
    chk("lit_amo_min_neg", last_rd, 32'hFFFFFFFE);
`endif

    // LR/SC
    st(B + 32'h30, 32'h00000000);
    at(4'hA, B + 32'h30, 32'h0);
    st(B + 32'h30, 32'h0000BEEF);
    at(4'hB, B + 32'h30, 32'h77);
`ifdef SOPHON_TCM_AMO_EN
    chk("lit_sc_killed", last_rd, 32'h1);
`endif
    ld(B + 32'h30);
    chk("lit_sc_killed_mem", last_rd, 32'h0000BEEF);
    at(4'hA, B + 32'h30, 32'h0);
    st(B + 32'h34, 32'h0000CAFE);
    at(4'hB, B + 32'h30, 32'h55);
`ifdef SOPHON_TCM_AMO_EN
    chk("lit_sc_ok", last_rd, 32'h0);
`endif
    ld(B + 32'h30);
`ifdef SOPHON_TCM_AMO_EN
    chk("lit_sc_ok_mem", last_rd, 32'h55);
`endif
    at(4'hB, B + 32'h30, 32'h66);
`ifdef SOPHON_TCM_AMO_EN
    chk("lit_sc_second", last_rd, 32'h1);
`endif
    ld(B + 32'h30);

    // reset in flight
    st(B + 32'h38, 32'h12345678);
    at(4'hA, B + 32'h38, 32'h0);
    rst_mid(B + 32'h38, 32'hDEAD0001);
    ld(B + 32'h38);
    chk("lit_reset_nowrite", last_rd, 32'h12345678);
    at(4'hB, B + 32'h38, 32'h99);
`ifdef SOPHON_TCM_AMO_EN
    chk("lit_sc_after_reset", last_rd, 32'h1);
`else
    chk("lit_sc_off_err", last_err, 1'b1);
`endif
    ld(B + 32'h38);

    // back-to-back store/load sweep
    for (int i = 0; i < 6; i++) st(B + 32'h80 + 32'(i * 4), 32'hC0DE0000 + 32'(i * 17));
    for (int i = 5; i >= 0; i--) ld(B + 32'h80 + 32'(i * 4));

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
